bin2bcd_serial: RTL and testbench
=================================

BIN2BCD_SERIAL -- requirements
Module: bin2bcd_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 10: binary input width.
REQ-002 SHALL have parameter DIGITS, default 3: number of BCD digits delivered; only WIDTH=10, DIGITS=3 is required to be verified.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: bin is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1: block can accept a new value.
REQ-007 SHALL have port bin, input, WIDTH: unsigned binary operand.
REQ-008 SHALL have port out_valid, output, 1: bcd and ovf hold a completed result.
REQ-009 SHALL have port out_ready, input, 1: downstream consumes the result.
REQ-010 SHALL have port bcd, output, 4*DIGITS: packed BCD, digit 0 (units) in bits [3:0]; each nibble feeds a per-digit BCD-to-Excess-3 encoder downstream.
REQ-011 SHALL have port ovf, output, 1: bin >= 10^DIGITS.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = (state==IDLE), out_valid = (state==DONE), both driven from registered state.
REQ-013 IDLE: on in_valid=1 SHALL capture bin into a shift register, clear a (DIGITS+1)-digit scratch register, load counter with WIDTH, and go to SHIFT.
REQ-014 IDLE with in_valid=0 SHALL remain in IDLE with no register change.
REQ-015 SHIFT: each cycle SHALL perform one double-dabble step: add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one bit; decrement counter.
REQ-016 SHALL go SHIFT->DONE on the edge performing the WIDTH-th step; the step count is exactly WIDTH.
REQ-017 On SHIFT->DONE edge SHALL register bcd = lower DIGITS digits of scratch result and ovf = (extra top digit != 0).
REQ-018 Latency: with acceptance at edge E, out_valid SHALL be 1 from edge E+WIDTH (10 cycles for default).
REQ-019 DONE: bcd and ovf SHALL be held stable while out_ready=0; on out_ready=1 SHALL go to IDLE at that edge.
REQ-020 in_valid SHALL be ignored in SHIFT and DONE; no input buffering, no overlap; next acceptance is the cycle after the output handshake at earliest.
REQ-021 bcd/ovf SHALL hold the last delivered result in IDLE and SHIFT; only updated on entry to DONE.
REQ-022 When ovf=0 every bcd nibble SHALL be 0..9; when ovf=1, bcd SHALL hold the low DIGITS decimal digits of bin (1023 -> 12'h023).
REQ-023 out_ready in IDLE/SHIFT SHALL have no effect.

Reset
REQ-024 rst=1 at an edge SHALL force state IDLE, bcd=0, ovf=0, counter=0, scratch and shift register=0, in any state including mid-SHIFT and DONE.
REQ-025 While rst=1, in_valid SHALL not be accepted; in_ready SHALL be 1 and out_valid 0 from the first edge with rst=1 onward.
REQ-026 An in-flight conversion aborted by reset SHALL produce no output.

Verification
REQ-027 Reset, then bin=0, in_valid 1 cycle -> out_valid after 10 cycles, bcd=12'h000, ovf=0.
REQ-028 bin=999 -> bcd=12'h999, ovf=0; bin=1023 -> bcd=12'h023, ovf=1.
REQ-029 bin=255, out_ready=0 for 5 cycles after out_valid, in_valid=1 with bin=7 during that time -> bcd stays 12'h255, in_ready=0, bin=7 not converted; out_ready=1 -> IDLE next edge.
REQ-030 Back-to-back: 128 then 64, out_ready=1, in_valid held high -> 12'h128 then 12'h064; second acceptance one cycle after first handshake; 12 cycles per result.
REQ-031 rst=1 for one cycle at step 5 of converting 500 -> out_valid never rises for 500, bcd=0, in_ready=1; next input 37 -> 12'h037.
REQ-032 Exhaustive sweep 0..1023 against reference model -> all bcd/ovf match, latency exactly 10 cycles each.

Source files
------------

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter using the shift-and-add-3 (double dabble)
// algorithm, one bit per clock. A conversion takes exactly WIDTH SHIFT
// cycles; the (DIGITS+1)-th scratch digit exists only to detect overflow.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Input side: in_ready is 1 only in IDLE, and bin is captured on that
// edge. Output side: out_valid is 1 only in DONE, and bcd/ovf stay stable
// until out_ready is seen. Inputs are ignored in every other state, and no
// value is buffered.
module bin2bcd_serial #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [1:0]            o_dbg_state
);

    localparam int SW = 4 * (DIGITS + 1);   // scratch width incl. overflow digit
    localparam int CW = $clog2(WIDTH + 1);  // step counter width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [WIDTH-1:0]      r_shift;
    logic [SW-1:0]         r_scratch;
    logic [CW-1:0]         r_cnt;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_ovf;

    logic [SW-1:0]         w_adj;
    logic [SW+WIDTH-1:0]   w_step;
    logic                  w_last;

    // Add-3 correction: every scratch digit >= 5 is bumped before the shift
    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < DIGITS + 1; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    // One double-dabble step: {scratch, shift} shifted left by one bit
    assign w_step = {w_adj[SW-2:0], r_shift, 1'b0};

    // Counter holds the number of steps still to do; 1 means this is the last
    assign w_last = (r_cnt == CW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_next_state = SHIFT;
            SHIFT:   if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    // Datapath: capture, shift steps, and result registration on DONE entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift   <= bin;
                        r_scratch <= '0;
                        r_cnt     <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    r_scratch <= w_step[SW+WIDTH-1:WIDTH];
                    r_shift   <= w_step[WIDTH-1:0];
                    r_cnt     <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_bcd <= w_step[WIDTH+4*DIGITS-1:WIDTH];
                        r_ovf <= |w_step[SW+WIDTH-1:WIDTH+4*DIGITS];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign bcd         = r_bcd;
    assign ovf         = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Bench for bin2bcd_serial: directed scenarios, random conversions and an
// exhaustive 0..1023 sweep against a decimal-arithmetic reference model.
module tb_bin2bcd_serial;

  localparam int WIDTH  = 10;
  localparam int DIGITS = 3;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     bin;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*DIGITS-1:0]  bcd;
  logic                 ovf;
  logic [1:0]           dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // expected {ovf, bcd} per accepted input
  logic [12:0] exp_q[$];

  bin2bcd_serial #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bin        (bin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .bcd        (bcd),
    .ovf        (ovf),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [12:0] ref_model(input int v);
    logic [3:0] d0, d1, d2;
    logic       o;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'((v / 100) % 10);
    o  = (v >= 1000);
    return {o, d2, d1, d0};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  // One full conversion with random backpressure of 'hold' cycles in DONE.
  task automatic convert(input int v, input int hold);
    int          lat;
    bit          seen;
    logic [12:0] exp;
    check("in_ready_pre", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    bin      = WIDTH'(v);
    exp_q.push_back(ref_model(v));
    tick();
    in_valid = 1'b0;
    bin      = WIDTH'($urandom);
    check("in_ready_busy", 32'(in_ready), 32'd0);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      tick();
      lat++;
      if (out_valid) seen = 1;
    end
    check("latency", 32'(lat), 32'd10);
    exp = exp_q.pop_front();
    check("result", 32'({ovf, bcd}), 32'(exp));
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      bin      = WIDTH'($urandom);
      tick();
      check("hold_val", 32'({ovf, bcd}), 32'(exp));
      check("hold_ovalid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_hold_val", 32'({ovf, bcd}), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          v1_at, v2_at;
    logic [12:0] r1, r2;
    bit          bad;

    rst = 1'b1; in_valid = 1'b1; bin = 10'd5; out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bcd", 32'({ovf, bcd}), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("rst_no_accept", 32'(in_ready), 32'd1);

    // directed values incl. boundaries
    convert(0, 0);
    convert(999, 1);
    convert(1023, 0);
    convert(1000, 2);

    // backpressure with ignored input during DONE
    in_valid = 1'b1; bin = 10'd255;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_val0", 32'({ovf, bcd}), 32'h255);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; bin = 10'd7;
      tick();
      check("bp_val", 32'({ovf, bcd}), 32'h255);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle", 32'(in_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid || !in_ready) bad = 1;
    end
    check("bp_7_not_converted", 32'(bad), 32'd0);

    // back-to-back with in_valid and out_ready held high
    in_valid = 1'b1; bin = 10'd128; out_ready = 1'b1;
    v1_at = -1; v2_at = -1; r1 = '0; r2 = '0;
    tick();
    bin = 10'd64;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (out_valid) begin
        if (v1_at < 0) begin v1_at = c; r1 = {ovf, bcd}; end
        else if (v2_at < 0) begin v2_at = c; r2 = {ovf, bcd}; end
      end
      if (c == 11) check("b2b_ready_gap", 32'(in_ready), 32'd1);
      if (c == 12) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    check("b2b_first_at", 32'(v1_at), 32'd10);
    check("b2b_first_val", 32'(r1), 32'h128);
    check("b2b_second_at", 32'(v2_at), 32'd22);
    check("b2b_second_val", 32'(r2), 32'h064);

    // reset mid-conversion
    in_valid = 1'b1; bin = 10'd500;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_bcd", 32'({ovf, bcd}), 32'd0);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) bad = 1;
    end
    check("abort_no_output", 32'(bad), 32'd0);
    convert(37, 0);

    // random values with random backpressure
    for (int i = 0; i < 40; i++) convert(int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)));

    // exhaustive sweep
    for (int v = 0; v < 1024; v++) convert(v, int'($urandom_range(0, 1)));

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
